// File: rtl/issue_scheduler_if.sv
// Handshake bundle between dispatch, the result-tag broadcast, the scheduler
// and the functional unit. The scheduler takes the slave side.
interface issue_scheduler_if #(
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) ();
  logic                 disp_valid;
  logic                 disp_ready;
  logic [TAG_W-1:0]     disp_rs;
  logic                 disp_rs_busy;
  logic [TAG_W-1:0]     disp_rt;
  logic                 disp_rt_busy;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 wake_valid;
  logic [TAG_W-1:0]     wake_tag;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [TAG_W-1:0]     issue_rs;
  logic [TAG_W-1:0]     issue_rt;

  modport master (
    output disp_valid, disp_rs, disp_rs_busy, disp_rt, disp_rt_busy, disp_payload,
    output wake_valid, wake_tag, issue_ready,
    input  disp_ready, issue_valid, issue_payload, issue_rs, issue_rt
  );

  modport slave (
    input  disp_valid, disp_rs, disp_rs_busy, disp_rt, disp_rt_busy, disp_payload,
    input  wake_valid, wake_tag, issue_ready,
    output disp_ready, issue_valid, issue_payload, issue_rs, issue_rt
  );
endinterface

// File: rtl/issue_scheduler.sv
// Oldest-first wakeup/select scheduler feeding one functional unit.
// Entries live in a compacting array: slot 0 is the oldest and valid slots
// are always contiguous from 0 to count-1.
module issue_scheduler #(
  parameter int ENTRIES   = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sys_i,
  issue_scheduler_if.slave          bus,
  output logic [$clog2(ENTRIES):0]  count_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]     rs;
    logic                 rs_busy;
    logic [TAG_W-1:0]     rt;
    logic                 rt_busy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             slot_q [ENTRIES];
  entry_t             slot_d [ENTRIES];
  entry_t             woken  [ENTRIES];
  entry_t             shifted[ENTRIES];
  entry_t             new_entry;
  logic [ENTRIES-1:0] valid_q, valid_d, shifted_v;
  logic [ENTRIES-1:0] ready;
  logic [CNT_W-1:0]   count_q, count_d, wr_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_fire, issue_fire;

  // Select: lowest-index slot with both operands ready, from registered state only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ready   = '0;
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ready[i] = valid_q[i] & ~slot_q[i].rs_busy & ~slot_q[i].rt_busy;
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end

  assign bus.issue_valid   = |ready;
  assign bus.issue_payload = bus.issue_valid ? slot_q[sel_idx].payload : '0;
  assign bus.issue_rs      = bus.issue_valid ? slot_q[sel_idx].rs      : '0;
  assign bus.issue_rt      = bus.issue_valid ? slot_q[sel_idx].rt      : '0;
  assign bus.disp_ready    = (count_q < CNT_W'(ENTRIES));
  assign disp_fire         = bus.disp_valid & bus.disp_ready;
  assign issue_fire        = bus.issue_valid & bus.issue_ready;
  assign count_o           = count_q;

  // Wakeup snoop on stored entries, plus the same-cycle bypass for the incoming one.
  always_comb begin
    woken = slot_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (bus.wake_valid && slot_q[i].rs == bus.wake_tag) woken[i].rs_busy = 1'b0;
      if (bus.wake_valid && slot_q[i].rt == bus.wake_tag) woken[i].rt_busy = 1'b0;
    end
    new_entry.rs      = bus.disp_rs;
    new_entry.rt      = bus.disp_rt;
    new_entry.payload = bus.disp_payload;
    new_entry.rs_busy = bus.disp_rs_busy & ~(bus.wake_valid && bus.disp_rs == bus.wake_tag);
    new_entry.rt_busy = bus.disp_rt_busy & ~(bus.wake_valid && bus.disp_rt == bus.wake_tag);
  end

  // Compaction on issue, then append of the dispatched entry at the new tail.
  always_comb begin
    shifted   = woken;
    shifted_v = '0;
    for (int i = 0; i < ENTRIES - 1; i++) begin
      shifted[i]   = woken[i + 1];
      shifted_v[i] = valid_q[i + 1];
    end
    slot_d  = woken;
    valid_d = valid_q;
    wr_idx  = count_q - CNT_W'(issue_fire);
    for (int i = 0; i < ENTRIES; i++) begin
      if (issue_fire && IDX_W'(i) >= sel_idx) begin
        slot_d[i]  = shifted[i];
        valid_d[i] = shifted_v[i];
      end
      if (disp_fire && CNT_W'(i) == wr_idx) begin
        slot_d[i]  = new_entry;
        valid_d[i] = 1'b1;
      end
    end
    unique case ({disp_fire, issue_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy state: reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (!rst_ni || sys_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Entry storage: no reset needed.
  always_ff @(posedge clk_i) begin
    // NOTE: the entry array is deliberately not reset; valid bits gate every use of it.
    slot_q <= slot_d;
  end
endmodule
